// File: rtl/hazard_stall_ctrl_if.sv
// Data-memory handshake bundle for hazard_stall_ctrl: the MEM-stage access
// request from the pipeline, the memory's ready, and the controller's request/error.
interface hazard_stall_ctrl_if;
  logic mem_access;
  logic dm_ready;
  logic dm_req;
  logic mem_err;

  modport master (
    input  mem_access,
    input  dm_ready,
    output dm_req,
    output mem_err
  );

  modport slave (
    output mem_access,
    output dm_ready,
    input  dm_req,
    input  mem_err
  );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Pipeline stall/flush sequencing for the 5-stage RV32I core: load-use, taken JB and
// variable-latency data memory with timeout. HAZARD_PERF_CNT_EN enables perf counters.
module hazard_stall_ctrl #(
  parameter int unsigned REG_AW      = 5,
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 5,
  parameter int unsigned PERF_W      = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  hazard_stall_ctrl_if.master    dm,
  input  logic [REG_AW-1:0]      id_rs1,
  input  logic [REG_AW-1:0]      id_rs2,
  input  logic                   id_rs1_used,
  input  logic                   id_rs2_used,
  input  logic [REG_AW-1:0]      ex_rd,
  input  logic                   ex_mem_read,
  input  logic                   ex_jb_taken,
  output logic                   pc_stall,
  output logic                   if_id_stall,
  output logic                   id_ex_stall,
  output logic                   ex_mem_stall,
  output logic                   if_id_flush,
  output logic                   id_ex_flush,
  output logic                   mem_wb_flush,
  output logic                   mem_err_sticky,
  output logic [PERF_W-1:0]      perf_lu_cnt,
  output logic [PERF_W-1:0]      perf_mem_cnt,
  output logic [PERF_W-1:0]      perf_flush_cnt
);

  typedef enum logic {ST_RUN, ST_WAIT} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             sticky_q, sticky_d;
  logic             mem_stall;
  logic             req;
  logic             err;
  logic             load_use;

  assign load_use = ex_mem_read && (ex_rd != '0) &&
                    ((id_rs1_used && (id_rs1 == ex_rd)) ||
                     (id_rs2_used && (id_rs2 == ex_rd)));

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    sticky_d   = sticky_q;
    mem_stall  = 1'b0;
    req        = 1'b0;
    err        = 1'b0;
    case (state_q)
      ST_RUN: begin
        req = dm.mem_access;
        if (dm.mem_access && !dm.dm_ready) begin
          mem_stall  = 1'b1;
          state_d    = ST_WAIT;
          wait_cnt_d = CNT_W'(1);
        end
      end
      ST_WAIT: begin
        req       = 1'b1;
        mem_stall = 1'b1;
        if (dm.dm_ready) begin
          mem_stall  = 1'b0;
          state_d    = ST_RUN;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == CNT_W'(MEM_TIMEOUT - 1)) begin
          // Abort: let the instruction retire rather than hang the pipeline.
          err        = 1'b1;
          sticky_d   = 1'b1;
          mem_stall  = 1'b0;
          req        = 1'b0;
          state_d    = ST_RUN;
          wait_cnt_d = '0;
        end else begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  // Outputs are gated by rst_n so a reset mid-access drops them without a clock edge.
  always_comb begin
    dm.dm_req    = 1'b0;
    dm.mem_err   = 1'b0;
    pc_stall     = 1'b0;
    if_id_stall  = 1'b0;
    id_ex_stall  = 1'b0;
    ex_mem_stall = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    mem_wb_flush = 1'b0;
    if (rst_n) begin
      dm.dm_req  = req;
      dm.mem_err = err;
      if (mem_stall) begin
        pc_stall     = 1'b1;
        if_id_stall  = 1'b1;
        id_ex_stall  = 1'b1;
        ex_mem_stall = 1'b1;
        mem_wb_flush = 1'b1;
      end else if (ex_jb_taken) begin
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end else if (load_use) begin
        pc_stall    = 1'b1;
        if_id_stall = 1'b1;
        id_ex_flush = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_RUN;
      wait_cnt_q <= '0;
      sticky_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      sticky_q   <= sticky_d;
    end
  end

  assign mem_err_sticky = sticky_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [PERF_W-1:0] perf_lu_q, perf_lu_d;
  logic [PERF_W-1:0] perf_mem_q, perf_mem_d;
  logic [PERF_W-1:0] perf_flush_q, perf_flush_d;

  // Events are taken from the resolved outputs so they follow the priority order.
  always_comb begin
    perf_lu_d    = perf_lu_q;
    perf_mem_d   = perf_mem_q;
    perf_flush_d = perf_flush_q;
    if (pc_stall && !ex_mem_stall && (perf_lu_q != '1))
      perf_lu_d = perf_lu_q + PERF_W'(1);
    if (ex_mem_stall && (perf_mem_q != '1))
      perf_mem_d = perf_mem_q + PERF_W'(1);
    if (if_id_flush && (perf_flush_q != '1))
      perf_flush_d = perf_flush_q + PERF_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_lu_q    <= '0;
      perf_mem_q   <= '0;
      perf_flush_q <= '0;
    end else begin
      perf_lu_q    <= perf_lu_d;
      perf_mem_q   <= perf_mem_d;
      perf_flush_q <= perf_flush_d;
    end
  end

  assign perf_lu_cnt    = perf_lu_q;
  assign perf_mem_cnt   = perf_mem_q;
  assign perf_flush_cnt = perf_flush_q;
`else
  assign perf_lu_cnt    = '0;
  assign perf_mem_cnt   = '0;
  assign perf_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed scoreboard bench for hazard_stall_ctrl: load-use, JB priority, memory
// waits, timeout and asynchronous reset during a wait.
module tb_hazard_stall_ctrl;
  localparam int unsigned PERF_W = 32;

  // Expected-vector bit layout:
  // [9]dm_req [8]pc_stall [7]if_id_stall [6]id_ex_stall [5]ex_mem_stall
  // [4]if_id_flush [3]id_ex_flush [2]mem_wb_flush [1]mem_err [0]mem_err_sticky
  localparam logic [9:0] NONE = 10'h000;
  localparam logic [9:0] REQ  = 10'h200;
  localparam logic [9:0] MS   = 10'h1E4;
  localparam logic [9:0] JB   = 10'h018;
  localparam logic [9:0] LU   = 10'h188;
  localparam logic [9:0] ERR  = 10'h002;
  localparam logic [9:0] STK  = 10'h001;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic id_rs1_used, id_rs2_used, ex_mem_read, ex_jb_taken;
  logic pc_stall, if_id_stall, id_ex_stall, ex_mem_stall;
  logic if_id_flush, id_ex_flush, mem_wb_flush, mem_err_sticky;
  logic [PERF_W-1:0] perf_lu_cnt, perf_mem_cnt, perf_flush_cnt;

  hazard_stall_ctrl_if dm_if ();

  hazard_stall_ctrl #(
    .REG_AW(5), .MEM_TIMEOUT(16), .CNT_W(5), .PERF_W(PERF_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .dm(dm_if),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_jb_taken(ex_jb_taken),
    .pc_stall(pc_stall), .if_id_stall(if_id_stall),
    .id_ex_stall(id_ex_stall), .ex_mem_stall(ex_mem_stall),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .mem_wb_flush(mem_wb_flush), .mem_err_sticky(mem_err_sticky),
    .perf_lu_cnt(perf_lu_cnt), .perf_mem_cnt(perf_mem_cnt),
    .perf_flush_cnt(perf_flush_cnt)
  );

  int checks = 0;
  int errors = 0;
  logic [9:0] exp_q[$];
  logic [PERF_W-1:0] exp_lu = '0, exp_mem = '0, exp_fl = '0;

  function automatic logic [9:0] observed();
    return {dm_if.dm_req, pc_stall, if_id_stall, id_ex_stall, ex_mem_stall,
            if_id_flush, id_ex_flush, mem_wb_flush, dm_if.mem_err, mem_err_sticky};
  endfunction

  task automatic drive(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                       input logic u2, input logic [4:0] rd, input logic mr,
                       input logic jb, input logic ma, input logic rdy);
    id_rs1 = rs1; id_rs1_used = u1; id_rs2 = rs2; id_rs2_used = u2;
    ex_rd = rd; ex_mem_read = mr; ex_jb_taken = jb;
    dm_if.mem_access = ma; dm_if.dm_ready = rdy;
  endtask

  task automatic check_now(input string tag);
    logic [9:0] e;
    logic [9:0] o;
    e = exp_q.pop_front();
    o = observed();
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, o, e);
    end
  endtask

  // One clock cycle: drive, queue expectation, compare mid-cycle, advance past the edge.
  task automatic step(input string tag, input logic [4:0] rs1, input logic u1,
                      input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                      input logic mr, input logic jb, input logic ma, input logic rdy,
                      input logic [9:0] e);
    drive(rs1, u1, rs2, u2, rd, mr, jb, ma, rdy);
    exp_q.push_back(e);
    @(negedge clk);
    check_now(tag);
`ifdef HAZARD_PERF_CNT_EN
    if (e[5]) exp_mem = exp_mem + 1;
    if (e[8] && !e[5]) exp_lu = exp_lu + 1;
    if (e[4]) exp_fl = exp_fl + 1;
`endif
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input string tag, input logic [9:0] e);
    step(tag, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, e);
  endtask

  task automatic check_perf(input string tag);
    checks++;
    assert (perf_lu_cnt === exp_lu) else begin
      errors++;
      $error("FAIL %s_lu observed=%0d expected=%0d", tag, perf_lu_cnt, exp_lu);
    end
    checks++;
    assert (perf_mem_cnt === exp_mem) else begin
      errors++;
      $error("FAIL %s_mem observed=%0d expected=%0d", tag, perf_mem_cnt, exp_mem);
    end
    checks++;
    assert (perf_flush_cnt === exp_fl) else begin
      errors++;
      $error("FAIL %s_flush observed=%0d expected=%0d", tag, perf_flush_cnt, exp_fl);
    end
  endtask

  initial begin
    // Reset held with active-looking inputs: everything must stay low.
    drive(5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0);
    #1;
    exp_q.push_back(NONE);
    check_now("reset_outputs");
    check_perf("reset_perf");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Load-use on rs1, single stall cycle then release as the load moves on.
    step("lu_rs1",     5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, LU);
    step("lu_release", 5'd5, 1'b1, 5'd0, 1'b0, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0, NONE);
    step("lu_rs2",     5'd0, 1'b0, 5'd7, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, LU);
    step("rs2_unused", 5'd0, 1'b0, 5'd7, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, NONE);
    step("lu_x0",      5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, NONE);
    step("no_load",    5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, NONE);

    // Zero-wait access: request without stall, FSM stays in RUN.
    step("zero_wait",  5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, REQ);
    idle("zero_wait_after", NONE);

    // 3-cycle access: ready on the third cycle.
    step("wait3_c1",   5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, REQ | MS);
    step("wait3_c2",   5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, REQ | MS);
    step("wait3_c3",   5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, REQ);
    idle("wait3_after", NONE);
    check_perf("wait3_perf");

    // JB beats load-use; inside a wait the memory stall beats both.
    step("jb_over_lu", 5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, JB);
    step("jb_wait_c1", 5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, REQ | MS);
    step("jb_wait_c2", 5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, REQ | MS);
    step("jb_wait_rdy",5'd5, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b1, 1'b1, REQ | JB);
    idle("jb_after", NONE);
    check_perf("prio_perf");

    // Timeout: 15 stalled cycles, abort in the 16th, sticky afterwards.
    for (int i = 1; i <= 15; i++)
      step($sformatf("to_c%0d", i), 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0,
           REQ | MS);
    step("to_c16",     5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, ERR);
    idle("to_after", STK);
    step("to_lu_ok",   5'd3, 1'b1, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, LU | STK);
    check_perf("to_perf");

    // Reset in the second wait cycle aborts at once.
    step("rw_c1",      5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, REQ | MS | STK);
    drive(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    #1;
    exp_q.push_back(REQ | MS | STK);
    check_now("rw_c2_pre");
    rst_n = 1'b0;
    #1;
    exp_q.push_back(NONE);
    check_now("rw_in_reset");
    exp_lu = '0; exp_mem = '0; exp_fl = '0;
    check_perf("rw_perf_reset");
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle("rw_release", NONE);
    step("rw_access",  5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, REQ);
    check_perf("rw_perf_after");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
Pipeline sequencing controller for the 5-stage RV32I core. It consumes the decode-side control (rs usage, memRead, wb_en, JB taken) and the data-memory handshake, and drives per-stage stall and flush for PC, IF/ID, ID/EX, EX/MEM and MEM/WB. It resolves load-use hazards, taken branches and jumps, and variable-latency data-memory waits. Memory waits are handled by an FSM with a timeout.

Parameters:
REG_AW, 5, register address width
MEM_TIMEOUT, 16, max wait cycles for dm_ready before abort (>=2)
CNT_W, 5, width of wait counter (must hold MEM_TIMEOUT-1)
PERF_W, 32, perf counter width (optional feature)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
id_rs1  in  REG_AW  rs1 of instruction in ID
id_rs2  in  REG_AW  rs2 of instruction in ID
id_rs1_used  in  1  ID instruction reads rs1
id_rs2_used  in  1  ID instruction reads rs2
ex_rd  in  REG_AW  rd of instruction in EX
ex_mem_read  in  1  EX instruction is a load (decoder memRead, via ID/EX)
ex_jb_taken  in  1  EX branch/jump taken (next_pc_sel)
mem_access  in  1  MEM-stage instruction is a load or store
dm_ready  in  1  data memory completes access this cycle
dm_req  out  1  data memory request
pc_stall  out  1  hold PC
if_id_stall  out  1  hold IF/ID
id_ex_stall  out  1  hold ID/EX
ex_mem_stall  out  1  hold EX/MEM
if_id_flush  out  1  clear IF/ID to NOP
id_ex_flush  out  1  clear ID/EX to NOP
mem_wb_flush  out  1  insert bubble into MEM/WB
mem_err  out  1  one-cycle pulse on memory timeout
mem_err_sticky  out  1  set on timeout, cleared only by reset
perf_lu_cnt  out  PERF_W  load-use stall cycles
perf_mem_cnt  out  PERF_W  memory wait cycles
perf_flush_cnt  out  PERF_W  branch/jump flush events

Behaviour:
- Reset: asynchronous, rst_n=0. State=RUN, wait_cnt=0, mem_err_sticky=0, perf counters=0. While rst_n=0, all stall, flush, dm_req and mem_err outputs are forced 0.
- FSM states are RUN and WAIT. Outputs are combinational from state and inputs. State, counters and sticky flag are registered.
- RUN: dm_req=mem_access. If mem_access=1 and dm_ready=0, mem_stall=1 and next=WAIT, wait_cnt<=1. If dm_ready=1 in the same cycle, the access is zero-wait: no stall, stay in RUN.
- WAIT: dm_req=1 and mem_stall=1.
  - dm_ready=1: mem_stall=0 this cycle, pipeline advances, next=RUN, wait_cnt<=0.
  - dm_ready=0 and wait_cnt==MEM_TIMEOUT-1: mem_err=1 for that cycle, mem_err_sticky<=1, mem_stall=0, dm_req=0, next=RUN. The instruction retires with undefined load data.
  - Otherwise wait_cnt increments.
- Output priority, highest first:
  1. mem_stall: pc_stall=if_id_stall=id_ex_stall=ex_mem_stall=1, mem_wb_flush=1, all other flushes=0. JB and load-use are ignored because EX is frozen and re-evaluated on release.
  2. ex_jb_taken: if_id_flush=id_ex_flush=1, no stalls. A concurrent load-use is suppressed because the ID instruction is flushed.
  3. load_use = ex_mem_read & (ex_rd!=0) & ((id_rs1_used & id_rs1==ex_rd) | (id_rs2_used & id_rs2==ex_rd)). When set: pc_stall=if_id_stall=1, id_ex_flush=1. The stall lasts exactly 1 cycle because the load advances to MEM.
  4. Otherwise all outputs are 0.
- ex_rd==x0 never causes a hazard.
- A reset asserted mid-WAIT aborts immediately: dm_req drops asynchronously.

Optional Feature:
HAZARD_PERF_CNT_EN:
- Defined: perf_lu_cnt increments each cycle load_use wins priority. perf_mem_cnt increments each cycle mem_stall=1. perf_flush_cnt increments each cycle the ex_jb_taken flush is applied. All three saturate at all-ones and are not incremented while rst_n=0.
- Undefined: the ports remain present and are tied to 0. No counter flops are synthesized.

Test Plan:
- Load-use: ex_mem_read=1, ex_rd=5, id_rs1=5, id_rs1_used=1 -> for exactly 1 cycle pc_stall=if_id_stall=id_ex_flush=1; with ex_rd=0 instead -> all outputs 0.
- Zero-wait memory: mem_access=1, dm_ready=1 in the same cycle -> dm_req=1, no stall, state stays RUN.
- 3-cycle wait: mem_access=1, dm_ready rises on the 3rd cycle -> stalls asserted and mem_wb_flush=1 for 2 cycles, released in the ready cycle; perf_mem_cnt=2 with HAZARD_PERF_CNT_EN.
- Timeout: MEM_TIMEOUT=16, dm_ready held 0 -> mem_err pulses in the 16th cycle of the access, mem_err_sticky=1 afterwards, dm_req=0 the next cycle.
- Priority: ex_jb_taken=1 with load-use true -> if_id_flush=id_ex_flush=1 and pc_stall=0. The same stimulus during WAIT -> only mem stalls, and the flush occurs in the dm_ready cycle.
- Reset in WAIT: drop rst_n on the 2nd wait cycle -> dm_req and stalls go 0 immediately. After release: state RUN, sticky=0, counters=0.
